// File: rtl/seq_divider_32bit.sv
// Multi-cycle unsigned 32-bit restoring divider: one quotient bit per clock,
// with trial subtraction done by a single subtractor_32bit instance.

module subtractor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        carry
);
  // carry=1 means no borrow, i.e. a >= b unsigned.
  assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + 33'd1;
endmodule

module seq_divider_32bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] div_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [4:0]  count;

  logic [31:0] trial;
  logic [31:0] diff;
  logic        carry;
  logic        ge;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic        accept;

  assign accept = start && (state != RUN);

  // One restoring step; rem_r[31] set means the shifted value exceeds 32 bits
  // and therefore certainly exceeds the divisor.
  assign trial = {rem_r[30:0], quo_r[31]};

  subtractor_32bit u_sub (
    .a     (trial),
    .b     (div_r),
    .diff  (diff),
    .carry (carry)
  );

  assign ge       = rem_r[31] | carry;
  assign rem_next = ge ? diff : trial;
  assign quo_next = {quo_r[30:0], ge};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor == 32'd0) ? DONE : RUN;
      RUN:  if (count == 5'd31) state_next = DONE;
      DONE: begin
        if (start) state_next = (divisor == 32'd0) ? DONE : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Visible results only change on an accepted start, at the last iteration, or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r       <= 32'd0;
      rem_r       <= 32'd0;
      quo_r       <= 32'd0;
      count       <= 5'd0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_r       <= divisor;
      div_by_zero <= 1'b0;
      if (divisor == 32'd0) begin
        quotient    <= 32'hFFFF_FFFF;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        rem_r <= 32'd0;
        quo_r <= dividend;
        count <= 5'd0;
      end
    end else if (state == RUN) begin
      rem_r <= rem_next;
      quo_r <= quo_next;
      count <= count + 5'd1;
      if (count == 5'd31) begin
        quotient  <= quo_next;
        remainder <= rem_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Directed bench for seq_divider_32bit: hand-computed quotients/remainders,
// latency, busy window, back-to-back, ignored start and mid-run reset.

module tb_seq_divider_32bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider_32bit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after an edge; the next edge is the start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Counts edges after the start edge until done, plus cycles with busy high.
  task automatic wait_done(input int base, output int lat, output int busy_cnt);
    lat      = base;
    busy_cnt = 0;
    while (!done && lat < base + 40) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input logic exp_dbz, input int exp_lat);
    int lat;
    int bc;
    start_op(a, b);
    wait_done(0, lat, bc);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, bc, exp_lat);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " remainder"}, remainder, exp_r);
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    tick();
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    tick();

    do_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    tick();
    check("done pulse width", {31'd0, done}, 32'd0);
    check("hold quotient idle", quotient, 32'd14);

    do_div("ffffffff/80000000", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 32);
    tick();
    do_div("ffffffff/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
    tick();

    do_div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    tick();
    check("5/0 done drops", {31'd0, done}, 32'd0);
    check("5/0 dbz held", {31'd0, div_by_zero}, 32'd1);
    check("5/0 remainder held", remainder, 32'd5);
    start_op(32'd9, 32'd3);
    check("9/3 dbz cleared at start", {31'd0, div_by_zero}, 32'd0);
    check("9/3 busy after start", {31'd0, busy}, 32'd1);
    wait_done(0, lat, bc);
    check("9/3 latency", lat, 32);
    check("9/3 quotient", quotient, 32'd3);
    check("9/3 remainder", remainder, 32'd0);
    tick();

    // Back-to-back: second start issued in the done cycle of the first.
    do_div("7/9", 32'd7, 32'd9, 32'd0, 32'd7, 1'b0, 32);
    do_div("50/8 b2b", 32'd50, 32'd8, 32'd6, 32'd2, 1'b0, 32);
    tick();

    // Start during RUN must be ignored.
    start_op(32'd1000, 32'd10);
    repeat (4) tick();
    start    = 1'b1;
    dividend = 32'd1;
    divisor  = 32'd1;
    tick();
    start    = 1'b0;
    check("ignored start busy", {31'd0, busy}, 32'd1);
    wait_done(5, lat, bc);
    check("ignored start latency", lat, 32);
    check("ignored start quotient", quotient, 32'd100);
    check("ignored start remainder", remainder, 32'd0);
    tick();

    // Reset in the middle of an operation.
    start_op(32'd1000, 32'd10);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset quotient", quotient, 32'd0);
    check("midreset remainder", remainder, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) done_seen++;
      tick();
    end
    check("midreset no activity", done_seen, 32'd0);
    do_div("20/6", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 32);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
